seq_detect_ctrl: RTL and testbench

Session controller for serial pattern detection. It accepts a byte stream over a valid/ready handshake and serializes each byte MSB-first. A programmable 1..PAT_MAX-bit pattern, matched in overlapping or non-overlapping mode, is detected against the bit stream. Matches are counted, and a session ends when the configured target count is reached or on abort. The block sits between the byte-wide stream source and the fixed-pattern Mealy detectors, and generalises them under start/done control.

---
 rtl/seq_detect_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Session controller: serializes a valid/ready byte stream MSB-first and counts
// matches of a programmable 1..PAT_MAX-bit pattern until a target count or abort.
module seq_detect_ctrl #(
  parameter  int PAT_MAX = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               busy,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               done,
  output logic               err_cfg
);

  localparam int BL_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [BL_W-1:0]    bits_left_q, bits_left_d;
  logic [PAT_MAX-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   seen_q, seen_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               match_q, match_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cur_bit;
  logic [PAT_MAX-1:0] window;
  logic [PAT_MAX-1:0] len_mask;
  logic [LEN_W:0]     seen_inc;
  logic [LEN_W-1:0]   seen_sat;
  logic [CNT_W-1:0]   count_inc;
  logic               hit;
  logic               accept;
  logic               cfg_bad;

  assign busy        = (state_q == S_RUN);
  assign in_ready    = (state_q == S_RUN) && (bits_left_q <= BL_W'(1));
  assign match_pulse = match_q;
  assign match_count = count_q;
  assign done        = done_q;
  assign err_cfg     = err_q;

  // Datapath terms shared by the matcher; window is the history plus the bit
  // being consumed this cycle, newest bit in position 0.
  assign cur_bit   = shreg_q[7];
  assign window    = {hist_q, cur_bit};
  assign len_mask  = ~({PAT_MAX{1'b1}} << len_q);
  assign seen_inc  = {1'b0, seen_q} + 1'b1;
  assign seen_sat  = (seen_inc > {1'b0, len_q}) ? len_q : seen_inc[LEN_W-1:0];
  assign count_inc = count_q + 1'b1;
  assign hit       = (seen_inc >= {1'b0, len_q}) && (((window ^ pat_q) & len_mask) == '0);
  assign accept    = in_valid && in_ready;
  assign cfg_bad   = (cfg_len == '0) || (cfg_len > LEN_W'(PAT_MAX)) || (cfg_target == '0);

  // NOTE: every *_d gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch instead of a mux.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    tgt_d       = tgt_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    hist_d      = hist_q;
    seen_d      = seen_q;
    count_d     = count_q;
    match_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            pat_d       = cfg_pattern;
            len_d       = cfg_len;
            ovl_d       = cfg_overlap;
            tgt_d       = cfg_target;
            count_d     = '0;
            hist_d      = '0;
            seen_d      = '0;
            bits_left_d = '0;
            state_d     = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          // Abort wins over a match landing on the same edge.
          state_d     = S_IDLE;
          bits_left_d = '0;
        end else begin
          if (bits_left_q != '0) begin
            shreg_d     = shreg_q << 1;
            bits_left_d = bits_left_q - 1'b1;
            hist_d      = window[PAT_MAX-2:0];
            seen_d      = seen_sat;
            if (hit) begin
              match_d = 1'b1;
              count_d = count_inc;
              if (!ovl_q) seen_d = '0;
              if (count_inc == tgt_q) begin
                done_d      = 1'b1;
                state_d     = S_IDLE;
                bits_left_d = '0;
              end
            end
          end
          // A byte loaded on the final bit edge keeps the stream gap-free.
          if (accept && (state_d == S_RUN)) begin
            shreg_d     = in_data;
            bits_left_d = BL_W'(8);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      shreg_q     <= '0;
      bits_left_q <= '0;
      hist_q      <= '0;
      seen_q      <= '0;
      count_q     <= '0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      tgt_q       <= tgt_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      hist_q      <= hist_d;
      seen_q      <= seen_d;
      count_q     <= count_d;
      match_q     <= match_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a bit-level pattern model queues expected
// matches as bytes are accepted; a negedge monitor pops and compares them.
module tb_seq_detect_ctrl;

  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(PAT_MAX + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PAT_MAX-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [7:0]         in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               busy;
  logic               match_pulse;
  logic [CNT_W-1:0]   match_count;
  logic               done;
  logic               err_cfg;

  seq_detect_ctrl #(.PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .done        (done),
    .err_cfg     (err_cfg)
  );

  typedef struct {
    int edge_n;
    int count;
    bit done;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_miss = 0;
  int         edge_no = 0;
  logic [7:0] stim[0:7];
  int         held;

  logic [PAT_MAX-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  int                 m_tgt;
  int                 m_cnt;
  bit                 m_live;
  bit                 m_win[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_no++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: keep the last m_len bits since the last restart point and compare
  // them oldest-first against pattern bits [len-1..0].
  function automatic void model_bit(input bit b, input int e);
    bit ok;
    if (!m_live) return;
    m_win.push_back(b);
    if (m_win.size() > m_len) void'(m_win.pop_front());
    if (m_win.size() == m_len) begin
      ok = 1'b1;
      for (int i = 0; i < m_len; i++)
        if (m_win[i] != m_pat[m_len-1-i]) ok = 1'b0;
      if (ok) begin
        m_cnt++;
        sb.push_back('{edge_n: e, count: m_cnt, done: (m_cnt == m_tgt)});
        if (!m_ovl) m_win.delete();
        if (m_cnt == m_tgt) m_live = 1'b0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (match_pulse) begin
        if (sb.size() == 0) begin
          check("unexpected_match", match_pulse, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("match_edge", edge_no, mon_e.edge_n);
          check("match_count", match_count, mon_e.count);
          check("done_flag", done, mon_e.done);
          if (mon_e.done) check("busy_at_done", busy, 1'b0);
        end
      end else if (done) begin
        check("done_without_match", done, 1'b0);
      end
    end
  end

  task automatic start_session(input logic [PAT_MAX-1:0] pat, input int len,
                               input bit ovl, input int tgt);
    @(posedge clk); #1;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    cfg_target  = CNT_W'(tgt);
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    // Garbage config after the start cycle must be ignored.
    cfg_pattern = '1;
    cfg_len     = LEN_W'(7);
    cfg_overlap = ~ovl;
    cfg_target  = CNT_W'(1);
    m_pat = pat; m_len = len; m_ovl = ovl; m_tgt = tgt;
    m_cnt = 0; m_live = 1'b1; m_win.delete();
    check("busy_after_start", busy, 1'b1);
    check("count_cleared", match_count, 0);
  endtask

  task automatic send_bytes(input int n);
    int  prev;
    int  guard;
    bit  acc;
    prev = 0;
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1;
      in_data  = stim[j];
      acc      = 1'b0;
      guard    = 0;
      while (!acc && guard < 16) begin
        @(negedge clk);
        check("in_ready", in_ready, (j == 0) || (edge_no >= prev + 7));
        acc = in_ready;
        guard++;
        @(posedge clk); #1;
      end
      if (!acc) begin
        check("accept_timeout", acc, 1'b1);
      end else begin
        if (j > 0) check("accept_edge", edge_no, prev + 8);
        prev = edge_no;
        for (int b = 0; b < 8; b++) model_bit(stim[j][7-b], prev + 1 + b);
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic abort_session();
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("busy_after_abort", busy, 1'b0);
    check("ready_after_abort", in_ready, 1'b0);
  endtask

  task automatic cfg_err(input int len, input int tgt);
    @(posedge clk); #1;
    cfg_pattern = 8'b1000;
    cfg_len     = LEN_W'(len);
    cfg_target  = CNT_W'(tgt);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_cfg_pulse", err_cfg, 1'b1);
    check("err_busy", busy, 1'b0);
    check("err_count_held", match_count, held);
    @(posedge clk); #1;
    check("err_cfg_one_cycle", err_cfg, 1'b0);
    check("err_still_idle", busy, 1'b0);
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_match_pulse", match_pulse, 1'b0);
    check("rst_match_count", match_count, 0);
    check("rst_done", done, 1'b0);
    check("rst_err_cfg", err_cfg, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Basic: 1000 twice in 0x88, session ends on the second match.
    start_session(8'b1000, 4, 1'b0, 2);
    stim[0] = 8'h88;
    send_bytes(1);
    drain();
    check("t1_count", match_count, 2);
    check("t1_busy", busy, 1'b0);

    // Overlapping 101 in 0xA8.
    start_session(8'b101, 3, 1'b1, 5);
    stim[0] = 8'hA8;
    send_bytes(1);
    drain();
    check("ovl_count", match_count, 2);
    check("ovl_busy", busy, 1'b1);
    abort_session();
    check("ovl_count_after_abort", match_count, 2);

    // Same stream, non-overlapping.
    start_session(8'b101, 3, 1'b0, 5);
    stim[0] = 8'hA8;
    send_bytes(1);
    drain();
    check("novl_count", match_count, 1);
    check("novl_busy", busy, 1'b1);
    abort_session();

    // Back-to-back streaming of 0x80, 0x01, 0x00.
    start_session(8'b1000, 4, 1'b0, 3);
    stim[0] = 8'h80; stim[1] = 8'h01; stim[2] = 8'h00;
    send_bytes(3);
    drain();
    check("b2b_count", match_count, m_cnt);
    check("b2b_busy", busy, 1'b1);
    abort_session();
    held = m_cnt;

    // Rejected starts.
    cfg_err(0, 1);
    cfg_err(4, 0);
    cfg_err(PAT_MAX + 1, 1);

    // Abort on the very edge that consumes the matching bit.
    start_session(8'b1000, 4, 1'b0, 5);
    m_live  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h88;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_no_pulse", match_pulse, 1'b0);
    check("abort_count", match_count, 0);
    check("abort_no_done", done, 1'b0);
    check("abort_idle", busy, 1'b0);

    // Asynchronous reset mid-byte while a match pulse is showing.
    start_session(8'b11, 2, 1'b1, 200);
    stim[0] = 8'hFF;
    send_bytes(1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_pulse", match_pulse, 1'b1);
    #1;
    rst_n = 1'b0;
    sb.delete();
    m_live = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_match_pulse", match_pulse, 1'b0);
    check("arst_match_count", match_count, 0);
    check("arst_done", done, 1'b0);
    check("arst_err_cfg", err_cfg, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Normal session after reset.
    start_session(8'b1000, 4, 1'b0, 2);
    stim[0] = 8'h88;
    send_bytes(1);
    drain();
    check("post_reset_count", match_count, 2);
    check("post_reset_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
